// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// register-number width and the packed bundle of stage-register controls.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    typedef struct packed {
        logic pc_wen;
        logic if_id_wen;
        logic id_ex_wen;
        logic ex_mem_wen;
        logic if_id_clear;
        logic id_ex_clear;
    } ctrl_t;

    // Free-running pipe: every stage advances, no bubbles.
    function automatic ctrl_t ctrl_run();
        ctrl_t c;
        c.pc_wen      = 1'b1;
        c.if_id_wen   = 1'b1;
        c.id_ex_wen   = 1'b1;
        c.ex_mem_wen  = 1'b1;
        c.if_id_clear = 1'b0;
        c.id_ex_clear = 1'b0;
        return c;
    endfunction

    // Whole pipe holds its contents.
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c.pc_wen      = 1'b0;
        c.if_id_wen   = 1'b0;
        c.id_ex_wen   = 1'b0;
        c.ex_mem_wen  = 1'b0;
        c.if_id_clear = 1'b0;
        c.id_ex_clear = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_dmrd;
    logic             ex_br_taken;
    logic             ex_ebreak;
    // mem_req/mem_ack: an access is issued in the cycle mem_req is high and
    // completes in the first cycle mem_ack is high (the same cycle allowed);
    // mem_req is not sampled again until the access has completed.
    logic             mem_req;
    logic             mem_ack;
    logic             resume;

    logic             pc_wen;
    logic             if_id_wen;
    logic             id_ex_wen;
    logic             ex_mem_wen;
    logic             if_id_clear;
    logic             id_ex_clear;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       dbg_state;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_dmrd,
               ex_br_taken, ex_ebreak, mem_req, mem_ack, resume,
        input  pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, if_id_clear,
               id_ex_clear, halted, mem_err, stall_cnt, dbg_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_dmrd,
               ex_br_taken, ex_ebreak, mem_req, mem_ack, resume,
        output pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, if_id_clear,
               id_ex_clear, halted, mem_err, stall_cnt, dbg_state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load currently in EX is about to write.
module hazard_cmp
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_dmrd,
    output logic             load_use
);

    logic rs1_hit;
    logic rs2_hit;
    logic rd_live;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign rd_live  = ex_dmrd && (ex_rd != '0);
    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use = rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: decides per cycle which stage registers write
// or bubble, and tracks memory-wait, halt, timeout error and stall count.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WAIT_W-1:0] wait_inc;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              load_use;
    ctrl_t             ctrl;

    hazard_cmp u_hazard_cmp (
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .id_use_rs1 (bus.id_use_rs1),
        .id_use_rs2 (bus.id_use_rs2),
        .ex_rd      (bus.ex_rd),
        .ex_dmrd    (bus.ex_dmrd),
        .load_use   (load_use)
    );

    assign wait_inc = wait_cnt_q + WAIT_W'(1);

    always_comb begin
        ctrl       = ctrl_run();
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;

        case (state_q)
            ST_RUN: begin
                if (bus.mem_req && !bus.mem_ack) begin
                    ctrl       = ctrl_freeze();
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end else if (bus.ex_ebreak) begin
                    // EBREAK leaves EX as a bubble while older work drains.
                    ctrl.pc_wen      = 1'b0;
                    ctrl.if_id_wen   = 1'b0;
                    ctrl.id_ex_clear = 1'b1;
                    state_d          = ST_HALT;
                end else if (bus.ex_br_taken) begin
                    // Taken branch outranks load-use: the consumer is flushed.
                    ctrl.if_id_clear = 1'b1;
                    ctrl.id_ex_clear = 1'b1;
                end else if (load_use) begin
                    ctrl.pc_wen      = 1'b0;
                    ctrl.if_id_wen   = 1'b0;
                    ctrl.id_ex_clear = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                if (bus.mem_ack) begin
                    state_d = ST_RUN;
                end else begin
                    ctrl       = ctrl_freeze();
                    wait_cnt_d = wait_inc;
                    if (wait_inc == WAIT_MAX) begin
                        mem_err_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                end
            end

            ST_HALT: begin
                ctrl = ctrl_freeze();
                if (bus.resume) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_wen && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_wen      = ctrl.pc_wen;
    assign bus.if_id_wen   = ctrl.if_id_wen;
    assign bus.id_ex_wen   = ctrl.id_ex_wen;
    assign bus.ex_mem_wen  = ctrl.ex_mem_wen;
    assign bus.if_id_clear = ctrl.if_id_clear;
    assign bus.id_ex_clear = ctrl.id_ex_clear;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.mem_err     = mem_err_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch flush, memory wait,
// timeout, EBREAK halt/resume and asynchronous reset.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (15),
        .CNT_W       (32)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, if_id_clear, id_ex_clear}
    logic [5:0] ctl;
    assign ctl = {bus.pc_wen, bus.if_id_wen, bus.id_ex_wen, bus.ex_mem_wen,
                  bus.if_id_clear, bus.id_ex_clear};

    localparam logic [5:0] C_RUN    = 6'b111100;
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_LU     = 6'b001101;
    localparam logic [5:0] C_BR     = 6'b111111;
    localparam logic [5:0] C_EBRK   = 6'b001101;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_use_rs1  = 1'b0;
        bus.id_use_rs2  = 1'b0;
        bus.ex_rd       = '0;
        bus.ex_dmrd     = 1'b0;
        bus.ex_br_taken = 1'b0;
        bus.ex_ebreak   = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.resume      = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #3;
        n_total++; if (ctl !== C_RUN) $display("FAIL reset_ctl: got %b want %b", ctl, C_RUN); else n_pass++;
        n_total++; if (bus.halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", bus.halted); else n_pass++;
        n_total++; if (bus.mem_err !== 1'b0) $display("FAIL reset_mem_err: got %b want 0", bus.mem_err); else n_pass++;
        n_total++; if (bus.stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt); else n_pass++;
        n_total++; if (bus.dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", bus.dbg_state); else n_pass++;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_load_use();
        bus.ex_dmrd = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
        #1;
        n_total++; if (ctl !== C_LU) $display("FAIL lu_rs1_ctl: got %b want %b", ctl, C_LU); else n_pass++;
        cyc();
        bus.ex_dmrd = 1'b0;
        #1;
        n_total++; if (ctl !== C_RUN) $display("FAIL lu_next_ctl: got %b want %b", ctl, C_RUN); else n_pass++;
        n_total++; if (bus.stall_cnt !== 32'd1) $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt); else n_pass++;
        bus.ex_dmrd = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
        #1;
        n_total++; if (ctl !== C_RUN) $display("FAIL lu_x0_ctl: got %b want %b", ctl, C_RUN); else n_pass++;
        bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b0;
        #1;
        n_total++; if (ctl !== C_RUN) $display("FAIL lu_nouse_ctl: got %b want %b", ctl, C_RUN); else n_pass++;
        bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b1;
        #1;
        n_total++; if (ctl !== C_LU) $display("FAIL lu_rs2_ctl: got %b want %b", ctl, C_LU); else n_pass++;
        cyc();
        idle();
        #1;
        n_total++; if (bus.stall_cnt !== 32'd2) $display("FAIL lu_rs2_stall_cnt: got %0d want 2", bus.stall_cnt); else n_pass++;
        cyc();
    endtask

    task automatic test_branch();
        bus.ex_dmrd = 1'b1; bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_use_rs1 = 1'b1;
        bus.ex_br_taken = 1'b1;
        #1;
        n_total++; if (ctl !== C_BR) $display("FAIL br_lu_ctl: got %b want %b", ctl, C_BR); else n_pass++;
        cyc();
        idle();
        #1;
        n_total++; if (bus.stall_cnt !== 32'd2) $display("FAIL br_stall_cnt: got %0d want 2", bus.stall_cnt); else n_pass++;
        n_total++; if (ctl !== C_RUN) $display("FAIL br_after_ctl: got %b want %b", ctl, C_RUN); else n_pass++;
        cyc();
    endtask

    task automatic test_mem_wait();
        bus.mem_req = 1'b1;
        #1;
        n_total++; if (ctl !== C_FREEZE) $display("FAIL mw_c0_ctl: got %b want %b", ctl, C_FREEZE); else n_pass++;
        for (int i = 1; i < 3; i++) begin
            cyc();
            #1;
            n_total++; if (ctl !== C_FREEZE) $display("FAIL mw_wait_ctl[%0d]: got %b want %b", i, ctl, C_FREEZE); else n_pass++;
            n_total++; if (bus.dbg_state !== 2'd1) $display("FAIL mw_wait_state[%0d]: got %0d want 1", i, bus.dbg_state); else n_pass++;
        end
        cyc();
        bus.mem_ack = 1'b1;
        #1;
        n_total++; if (ctl !== C_RUN) $display("FAIL mw_ack_ctl: got %b want %b", ctl, C_RUN); else n_pass++;
        cyc();
        idle();
        #1;
        n_total++; if (bus.dbg_state !== 2'd0) $display("FAIL mw_ret_state: got %0d want 0", bus.dbg_state); else n_pass++;
        n_total++; if (bus.stall_cnt !== 32'd5) $display("FAIL mw_stall_cnt: got %0d want 5", bus.stall_cnt); else n_pass++;
        bus.mem_req = 1'b1; bus.mem_ack = 1'b1;
        #1;
        n_total++; if (ctl !== C_RUN) $display("FAIL mw_same_ack_ctl: got %b want %b", ctl, C_RUN); else n_pass++;
        cyc();
        idle();
        #1;
        n_total++; if (bus.dbg_state !== 2'd0) $display("FAIL mw_same_ack_state: got %0d want 0", bus.dbg_state); else n_pass++;
        n_total++; if (bus.stall_cnt !== 32'd5) $display("FAIL mw_same_ack_cnt: got %0d want 5", bus.stall_cnt); else n_pass++;
        cyc();
    endtask

    task automatic test_timeout();
        bus.mem_req = 1'b1;
        cyc();
        for (int i = 0; i < 14; i++) cyc();
        #1;
        n_total++; if (bus.dbg_state !== 2'd1) $display("FAIL to_pre_state: got %0d want 1", bus.dbg_state); else n_pass++;
        n_total++; if (bus.mem_err !== 1'b0) $display("FAIL to_pre_err: got %b want 0", bus.mem_err); else n_pass++;
        cyc();
        bus.mem_req = 1'b0;
        #1;
        n_total++; if (bus.halted !== 1'b1) $display("FAIL to_halted: got %b want 1", bus.halted); else n_pass++;
        n_total++; if (bus.mem_err !== 1'b1) $display("FAIL to_mem_err: got %b want 1", bus.mem_err); else n_pass++;
        n_total++; if (bus.stall_cnt !== 32'd21) $display("FAIL to_stall_cnt: got %0d want 21", bus.stall_cnt); else n_pass++;
        n_total++; if (ctl !== C_FREEZE) $display("FAIL to_halt_ctl: got %b want %b", ctl, C_FREEZE); else n_pass++;
        bus.resume = 1'b1;
        cyc();
        bus.resume = 1'b0;
        #1;
        n_total++; if (bus.halted !== 1'b0) $display("FAIL to_resume_halted: got %b want 0", bus.halted); else n_pass++;
        n_total++; if (bus.mem_err !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", bus.mem_err); else n_pass++;
        n_total++; if (ctl !== C_RUN) $display("FAIL to_resume_ctl: got %b want %b", ctl, C_RUN); else n_pass++;
        n_total++; if (bus.stall_cnt !== 32'd22) $display("FAIL to_resume_cnt: got %0d want 22", bus.stall_cnt); else n_pass++;
        cyc();
    endtask

    task automatic test_ebreak();
        bus.resume = 1'b1;
        cyc();
        bus.resume = 1'b0;
        #1;
        n_total++; if (bus.dbg_state !== 2'd0) $display("FAIL eb_stray_resume: got %0d want 0", bus.dbg_state); else n_pass++;
        bus.ex_ebreak = 1'b1;
        #1;
        n_total++; if (ctl !== C_EBRK) $display("FAIL eb_ctl: got %b want %b", ctl, C_EBRK); else n_pass++;
        n_total++; if (bus.halted !== 1'b0) $display("FAIL eb_halted_early: got %b want 0", bus.halted); else n_pass++;
        cyc();
        bus.ex_ebreak = 1'b0;
        #1;
        n_total++; if (bus.halted !== 1'b1) $display("FAIL eb_halted: got %b want 1", bus.halted); else n_pass++;
        n_total++; if (ctl !== C_FREEZE) $display("FAIL eb_halt_ctl: got %b want %b", ctl, C_FREEZE); else n_pass++;
        cyc();
        #1;
        n_total++; if (bus.halted !== 1'b1) $display("FAIL eb_hold: got %b want 1", bus.halted); else n_pass++;
        bus.resume = 1'b1;
        cyc();
        bus.resume = 1'b0;
        #1;
        n_total++; if (bus.halted !== 1'b0) $display("FAIL eb_resume: got %b want 0", bus.halted); else n_pass++;
        n_total++; if (bus.stall_cnt !== 32'd25) $display("FAIL eb_stall_cnt: got %0d want 25", bus.stall_cnt); else n_pass++;
        cyc();
    endtask

    task automatic test_reset_mem_wait();
        bus.mem_req = 1'b1;
        cyc();
        cyc();
        #1;
        n_total++; if (bus.dbg_state !== 2'd1) $display("FAIL rmw_pre_state: got %0d want 1", bus.dbg_state); else n_pass++;
        idle();
        rst = 1'b1;
        #1;
        n_total++; if (bus.dbg_state !== 2'd0) $display("FAIL rmw_state: got %0d want 0", bus.dbg_state); else n_pass++;
        n_total++; if (bus.stall_cnt !== 32'd0) $display("FAIL rmw_stall_cnt: got %0d want 0", bus.stall_cnt); else n_pass++;
        n_total++; if (bus.mem_err !== 1'b0) $display("FAIL rmw_mem_err: got %b want 0", bus.mem_err); else n_pass++;
        n_total++; if (ctl !== C_RUN) $display("FAIL rmw_ctl: got %b want %b", ctl, C_RUN); else n_pass++;
        n_total++; if (bus.halted !== 1'b0) $display("FAIL rmw_halted: got %b want 0", bus.halted); else n_pass++;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_ebreak();
        test_reset_mem_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control block that drives the enable and clear inputs of the stage registers (PC, IF/ID, ID/EX, EX/MEM) of the five-stage RISC-V core. It detects load-use hazards, flushes on taken branches/jumps resolved in EX, freezes the pipe while a data-memory access is outstanding, and halts on EBREAK until an external resume pulse. It is the consumer-side partner of the stage registers: they only store, this block decides when they write or bubble.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent in MEM_WAIT before error.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_rs1, id_rs2  in  5 each  source register numbers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_dmrd  in  1  EX instruction is a load.
- ex_br_taken  in  1  branch/jump resolved taken in EX.
- ex_ebreak  in  1  EX instruction is EBREAK.
- mem_req  in  1  MEM stage is issuing a data-memory access this cycle.
- mem_ack  in  1  data memory completes the access.
- resume  in  1  single-cycle pulse leaving HALT.
- pc_wen, if_id_wen, id_ex_wen, ex_mem_wen  out  1 each  stage register write enables.
- if_id_clear, id_ex_clear  out  1 each  bubble insertion (zero instruction and controls).
- halted  out  1  state is HALT.
- mem_err  out  1  sticky, set on memory timeout.
- stall_cnt  out  CNT_W  cycles in which pc_wen was 0.

## Operation
- States: RUN, MEM_WAIT, HALT. Reset: RUN, wait counter 0, mem_err 0, stall_cnt 0.
- RUN, priority highest first:
  - mem_req && !mem_ack: go MEM_WAIT; this cycle all four wen = 0, clears 0.
  - ex_ebreak: go HALT; this cycle pc_wen = if_id_wen = 0, id_ex_clear = 1, ex_mem_wen = 1 (older instructions drain one stage).
  - ex_br_taken: pc_wen = 1, if_id_clear = 1, id_ex_clear = 1, other wen 1.
  - load-use: ex_dmrd && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)): pc_wen = if_id_wen = 0, id_ex_clear = 1, id_ex_wen = ex_mem_wen = 1.
  - otherwise all wen 1, clears 0.
- Branch in same cycle as load-use: branch wins (the dependent instruction is flushed anyway).
- MEM_WAIT: all wen 0, clears 0. Wait counter increments each cycle. mem_ack: return RUN, that cycle all wen 1. Counter reaching MEM_TIMEOUT without ack: set mem_err, go HALT.
- HALT: all wen 0, clears 0, halted 1. resume: return RUN next cycle; resume outside HALT ignored. mem_err cleared only by rst.
- stall_cnt increments every cycle with pc_wen == 0, saturates at all-ones.

## Timing
- Outputs are combinational from state and current inputs (Mealy); state, counters, mem_err registered on clk.
- Load-use stall lasts exactly one cycle: next cycle the load has moved to MEM, comparison no longer matches.
- Branch flush: one cycle, two bubbles (IF/ID and ID/EX).
- mem_ack in the same cycle as mem_req in RUN: no stall.
- Wait counter cleared on every MEM_WAIT entry; timeout exactly MEM_TIMEOUT cycles after entry.
- rst mid-MEM_WAIT or mid-HALT: immediate return to RUN, all outputs at reset values (all wen 1, clears 0, halted 0).

## Structure
- Shared package: state encoding (RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2), register-number width constant 5.
- One sub-module natural: hazard_cmp (pure combinational load-use comparator); FSM and counters in the top.

## Test plan
- Load-use: ex_dmrd = 1, ex_rd = 5, id_rs1 = 5, id_use_rs1 = 1 -> one cycle pc_wen = 0, if_id_wen = 0, id_ex_clear = 1; stall_cnt = 1; ex_rd = 0 gives no stall.
- Branch + load-use together: ex_br_taken = 1 with matching load -> if_id_clear = id_ex_clear = 1, pc_wen = 1.
- Memory wait: mem_req = 1, ack after 3 cycles -> all wen 0 for 3 cycles, RUN on ack cycle with all wen 1, stall_cnt = 3.
- Timeout: mem_req, no ack for 15 cycles -> mem_err = 1, halted = 1; resume -> RUN, mem_err stays 1.
- EBREAK: ex_ebreak = 1 -> id_ex_clear = 1, halted next cycle; resume pulse -> RUN next cycle.
- Reset during MEM_WAIT: rst asserted asynchronously -> state RUN, stall_cnt = 0, all wen 1 without a clock edge.
